pe_job_scheduler: RTL and testbench

Sequences the single-row convolution Processing_element through a stream of job descriptors. Each descriptor gives a stride, a filter size and the number of partial sums the job produces. The scheduler accepts one descriptor at a time and applies the configuration to the PE. It pulses the PE `Start`, counts the PE's Psum-buffer writes until the job is complete, and then reports done. A watchdog and an abort path guarantee return to idle if the PE stalls.

---
 rtl/pe_job_scheduler_pkg.sv | 18 +
 rtl/pe_watchdog.sv | 31 +++
 rtl/pe_job_scheduler.sv | 128 ++++++++++++
 tb/tb_pe_job_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_job_scheduler_pkg.sv
// Shared definitions for PE job schedulers: state encoding and default widths.
package pe_job_scheduler_pkg;

  localparam int DEF_STRIDE_WIDTH      = 2;
  localparam int DEF_FILTER_SIZE_WIDTH = 3;
  localparam int DEF_COUNT_WIDTH       = 8;
  localparam int DEF_TIMEOUT_WIDTH     = 12;
  localparam int DEF_TIMEOUT_CYCLES    = 4000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    FIN   = 3'd3,
    ERR   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/pe_watchdog.sv
// Stall watchdog: counts enabled, non-held cycles and flags expiry at TIMEOUT_CYCLES-1.
module pe_watchdog #(
  parameter int TIMEOUT_WIDTH  = 12,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic hold_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] cnt_q;

  // Saturates at LAST so the expiry flag stays asserted until cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !hold_i && cnt_q != LAST) begin
      cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/pe_job_scheduler.sv
// Sequences a single-row convolution PE through job descriptors, counting its
// Psum-buffer writes and guarding against stalls with a watchdog and abort.
module pe_job_scheduler
  import pe_job_scheduler_pkg::*;
#(
  parameter int STRIDE_WIDTH      = DEF_STRIDE_WIDTH,
  parameter int FILTER_SIZE_WIDTH = DEF_FILTER_SIZE_WIDTH,
  parameter int COUNT_WIDTH       = DEF_COUNT_WIDTH,
  parameter int TIMEOUT_WIDTH     = DEF_TIMEOUT_WIDTH,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [STRIDE_WIDTH-1:0]      cmd_stride,
  input  logic [FILTER_SIZE_WIDTH-1:0] cmd_filter_size,
  input  logic [COUNT_WIDTH-1:0]       cmd_psum_count,
  input  logic                         abort,
  output logic                         pe_start,
  output logic [STRIDE_WIDTH-1:0]      pe_stride,
  output logic [FILTER_SIZE_WIDTH-1:0] pe_filter_size,
  input  logic                         pe_wen_psum,
  input  logic                         pe_ready_psum,
  output logic                         busy,
  output logic [COUNT_WIDTH-1:0]       psum_done_cnt,
  output logic                         done,
  output logic                         error
);

  sched_state_e                 state_q;
  logic                         pe_start_q, done_q, error_q;
  logic [STRIDE_WIDTH-1:0]      stride_q;
  logic [FILTER_SIZE_WIDTH-1:0] filter_q;
  logic [COUNT_WIDTH-1:0]       target_q, cnt_q;
  logic [COUNT_WIDTH-1:0]       cnt_d;
  logic                         fire, accept, in_run, wd_expired;

  assign fire   = pe_wen_psum & pe_ready_psum;
  assign in_run = (state_q == RUN);
  assign accept = (state_q == IDLE) && cmd_valid && (cmd_stride != '0) &&
                  (cmd_filter_size != '0) && (cmd_psum_count != '0);
  assign cnt_d  = cnt_q + COUNT_WIDTH'(1);

  pe_watchdog #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (accept | (in_run & fire)),
    .en_i     (in_run & ~fire),
    .hold_i   (~pe_ready_psum),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pe_start_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      stride_q   <= '0;
      filter_q   <= '0;
      target_q   <= '0;
      cnt_q      <= '0;
    end else begin
      pe_start_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_stride == '0 || cmd_filter_size == '0) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else if (cmd_psum_count == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= START;
              pe_start_q <= 1'b1;
              stride_q   <= cmd_stride;
              filter_q   <= cmd_filter_size;
              target_q   <= cmd_psum_count;
              cnt_q      <= '0;
            end
          end
        end
        START: begin
          if (abort) begin
            state_q <= ERR;
            error_q <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // A write on the expiry cycle clears the watchdog, so it wins over timeout.
          if (abort) begin
            state_q <= ERR;
            error_q <= 1'b1;
          end else if (fire) begin
            cnt_q <= cnt_d;
            if (cnt_d == target_q) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end else if (wd_expired) begin
            state_q <= ERR;
            error_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q == START) || (state_q == RUN);
  assign pe_start       = pe_start_q;
  assign done           = done_q;
  assign error          = error_q;
  assign pe_stride      = stride_q;
  assign pe_filter_size = filter_q;
  assign psum_done_cnt  = cnt_q;

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Self-checking bench for pe_job_scheduler: directed test-plan scenarios plus
// randomized traffic, all compared every cycle against a behavioural job model.
module tb_pe_job_scheduler;

  localparam int TMO = 16;

  // Model phases of a job's life.
  localparam int P_WAIT = 10, P_KICK = 11, P_WORK = 12, P_OK = 13, P_BAD = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_stride = '0;
  logic [2:0] cmd_filter_size = '0;
  logic [7:0] cmd_psum_count = '0;
  logic       abort = 1'b0;
  logic       pe_wen_psum = 1'b0;
  logic       pe_ready_psum = 1'b1;
  logic       cmd_ready, pe_start, busy, done, error;
  logic [1:0] pe_stride;
  logic [2:0] pe_filter_size;
  logic [7:0] psum_done_cnt;

  pe_job_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_stride     (cmd_stride),
    .cmd_filter_size(cmd_filter_size),
    .cmd_psum_count (cmd_psum_count),
    .abort          (abort),
    .pe_start       (pe_start),
    .pe_stride      (pe_stride),
    .pe_filter_size (pe_filter_size),
    .pe_wen_psum    (pe_wen_psum),
    .pe_ready_psum  (pe_ready_psum),
    .busy           (busy),
    .psum_done_cnt  (psum_done_cnt),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: one job at a time, outcome decided by the descriptor,
  // the count of accepted writes and the length of the current silence.
  int e_ph = P_WAIT, e_start = 0, e_done = 0, e_err = 0;
  int e_stride = 0, e_filt = 0, e_target = 0, e_cnt = 0, e_quiet = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_ph = P_WAIT; e_start = 0; e_done = 0; e_err = 0;
      e_stride = 0; e_filt = 0; e_target = 0; e_cnt = 0; e_quiet = 0;
    end else begin
      e_start = 0; e_done = 0; e_err = 0;
      case (e_ph)
        P_WAIT: if (cmd_valid) begin
          if (cmd_stride == 0 || cmd_filter_size == 0) begin e_ph = P_BAD; e_err = 1; end
          else if (cmd_psum_count == 0) begin e_ph = P_OK; e_done = 1; end
          else begin
            e_ph = P_KICK; e_start = 1;
            e_stride = cmd_stride; e_filt = cmd_filter_size; e_target = cmd_psum_count;
            e_cnt = 0; e_quiet = 0;
          end
        end
        P_KICK: if (abort) begin e_ph = P_BAD; e_err = 1; end else e_ph = P_WORK;
        P_WORK: begin
          if (abort) begin e_ph = P_BAD; e_err = 1; end
          else if (pe_wen_psum && pe_ready_psum) begin
            e_cnt++; e_quiet = 0;
            if (e_cnt == e_target) begin e_ph = P_OK; e_done = 1; end
          end else if (e_quiet == TMO - 1) begin e_ph = P_BAD; e_err = 1; end
          else if (pe_ready_psum) e_quiet++;
        end
        default: e_ph = P_WAIT;
      endcase
    end
  end

  int n_start = 0, n_done = 0, n_err = 0;

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, e_ph == P_WAIT);
    chk("busy", busy, e_ph == P_KICK || e_ph == P_WORK);
    chk("pe_start", pe_start, e_start);
    chk("done", done, e_done);
    chk("error", error, e_err);
    chk("pe_stride", pe_stride, e_stride);
    chk("pe_filter_size", pe_filter_size, e_filt);
    chk("psum_done_cnt", psum_done_cnt, e_cnt);
    if (pe_start === 1'b1) n_start++;
    if (done === 1'b1) n_done++;
    if (error === 1'b1) n_err++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int s, input int f, input int c);
    cmd_stride = 2'(s); cmd_filter_size = 3'(f); cmd_psum_count = 8'(c);
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) step();
    chk("send_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  int b_start, b_done, b_err, kk;

  initial begin
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", psum_done_cnt, 0);
    rst = 1'b1;
    step();

    // Normal job
    b_start = n_start; b_done = n_done;
    send(2, 5, 4);
    chk("norm_start", pe_start, 1);
    step();
    pe_wen_psum = 1'b1;
    repeat (4) step();
    pe_wen_psum = 1'b0;
    chk("norm_done", done, 1);
    chk("norm_cnt", psum_done_cnt, 4);
    step();
    chk("norm_idle", cmd_ready, 1);
    chk("norm_stride", pe_stride, 2);
    chk("norm_filt", pe_filter_size, 5);
    chk("norm_nstart", n_start - b_start, 1);
    chk("norm_ndone", n_done - b_done, 1);

    // Invalid descriptors
    b_start = n_start; b_done = n_done; b_err = n_err;
    send(0, 3, 2);
    chk("inv_err_stride", error, 1);
    step();
    send(1, 0, 2);
    chk("inv_err_filt", error, 1);
    step();
    send(1, 1, 0);
    chk("inv_done_cnt0", done, 1);
    step();
    chk("inv_nerr", n_err - b_err, 2);
    chk("inv_ndone", n_done - b_done, 1);
    chk("inv_nstart", n_start - b_start, 0);
    chk("inv_stride_kept", pe_stride, 2);

    // Timeout after a single write
    send(1, 2, 3);
    step();
    pe_wen_psum = 1'b1;
    step();
    pe_wen_psum = 1'b0;
    kk = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      kk = k;
      if (error) break;
    end
    chk("tmo_latency", kk, 16);
    chk("tmo_cnt", psum_done_cnt, 1);
    step();
    chk("tmo_idle", cmd_ready, 1);

    // Back-pressure holds the watchdog
    b_err = n_err; b_done = n_done;
    send(1, 2, 3);
    step();
    pe_ready_psum = 1'b0; pe_wen_psum = 1'b1;
    repeat (50) step();
    chk("bp_noerr", n_err - b_err, 0);
    chk("bp_busy", busy, 1);
    chk("bp_cnt", psum_done_cnt, 0);
    pe_ready_psum = 1'b1;
    repeat (3) step();
    pe_wen_psum = 1'b0;
    chk("bp_done", done, 1);
    step();

    // Abort mid-RUN, then a fresh job
    b_done = n_done;
    send(1, 1, 5);
    step();
    pe_wen_psum = 1'b1;
    repeat (2) step();
    pe_wen_psum = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_err", error, 1);
    chk("abort_cnt", psum_done_cnt, 2);
    step();
    send(3, 4, 1);
    chk("abort_restart", pe_start, 1);
    step();
    pe_wen_psum = 1'b1;
    step();
    pe_wen_psum = 1'b0;
    chk("abort_new_done", done, 1);
    chk("abort_new_stride", pe_stride, 3);
    chk("abort_ndone", n_done - b_done, 1);
    step();

    // Back-to-back with cmd_valid held high
    b_start = n_start; b_done = n_done;
    cmd_stride = 2'd1; cmd_filter_size = 3'd2; cmd_psum_count = 8'd3; cmd_valid = 1'b1;
    pe_wen_psum = 1'b1;
    step();
    cmd_stride = 2'd2; cmd_filter_size = 3'd3; cmd_psum_count = 8'd2;
    chk("b2b_first_stride", pe_stride, 1);
    for (int k = 0; k < 30 && (n_start - b_start) < 2; k++) step();
    cmd_valid = 1'b0;
    chk("b2b_second_stride", pe_stride, 2);
    for (int k = 0; k < 30 && (n_done - b_done) < 2; k++) step();
    pe_wen_psum = 1'b0;
    step();
    chk("b2b_nstart", n_start - b_start, 2);
    chk("b2b_ndone", n_done - b_done, 2);

    // Asynchronous reset during RUN
    send(1, 1, 5);
    step();
    pe_wen_psum = 1'b1;
    repeat (2) step();
    pe_wen_psum = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_start", pe_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_stride", pe_stride, 0);
    chk("arst_filt", pe_filter_size, 0);
    chk("arst_cnt", psum_done_cnt, 0);
    chk("arst_done_err", {done, error}, 0);
    step();
    rst = 1'b1;
    send(2, 2, 2);
    step();
    pe_wen_psum = 1'b1;
    repeat (2) step();
    pe_wen_psum = 1'b0;
    chk("arst_next_done", done, 1);
    step();

    // Randomized traffic; quiet spells provoke timeouts
    for (int i = 0; i < 2000; i++) begin
      automatic bit quiet = ((i / 200) % 3) == 2;
      cmd_valid       = ($urandom_range(0, 1) == 1);
      cmd_stride      = 2'($urandom_range(0, 3));
      cmd_filter_size = 3'($urandom_range(0, 7));
      cmd_psum_count  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      pe_wen_psum     = quiet ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) != 0);
      pe_ready_psum   = ($urandom_range(0, 7) != 0);
      abort           = ($urandom_range(0, 63) == 0);
      step();
    end
    cmd_valid = 1'b0; abort = 1'b0; pe_wen_psum = 1'b0; pe_ready_psum = 1'b1;
    repeat (TMO + 4) step();
    chk("final_idle", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
